serial_mac_accum: RTL and testbench

//  Bit-serial accumulator placed directly downstream of the bit-serial multiplier stage.
//  - Consumes product bits LSB-first, one per accepted cycle.
//  - Adds each W-bit product frame into a W-bit running sum (mod 2^W) using one serial full adder.
//  - After K frames, presents the sum in parallel and pulses result_valid for one cycle.
//  - Forms the multiply-accumulate (dot-product) tail of the serial datapath.

---
 rtl/serial_mac_accum_pkg.sv | 23 ++
 rtl/serial_mac_accum_if.sv | 27 ++
 rtl/serial_mac_accum_fa_cell.sv | 27 ++
 rtl/serial_mac_accum.sv | 99 +++++++++
 tb/tb_serial_mac_accum.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/serial_mac_accum_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_pkg: shared types and helpers for the bit-serial multiply datapath.
// Revision: 1.0
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_mac_accum_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_mac_accum_if: control, serial input and parallel result bundle.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface serial_mac_accum_if #(
  parameter int W = 16
);
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;
  logic         overflow;

  modport master (
    output start, bit_in, bit_valid,
    input  busy, result, result_valid, overflow
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output busy, result, result_valid, overflow
  );
endinterface
`default_nettype wire

// File: rtl/serial_mac_accum_fa_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_fa_cell: 1-bit full adder whose carry is held in a flop between steps.
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_fa_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic co_q
);
  assign s = a ^ b ^ co_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      co_q <= 1'b0;
    else if (clr)
      co_q <= 1'b0;
    else if (en)
      co_q <= (a & b) | (a & co_q) | (b & co_q);
  end
endmodule
`default_nettype wire

// File: rtl/serial_mac_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_mac_accum: sums K LSB-first W-bit product frames with one serial adder.
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_mac_accum
  import mult_pkg::*;
#(
  parameter int W = 16,
  parameter int K = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_mac_accum_if.slave  bus
);
  localparam int BW = clog2(W);
  localparam int FW = clog2(K + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ACC  = ACC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]    state;
  logic [W-1:0]  acc;
  logic [BW-1:0] bit_cnt;
  logic [FW-1:0] frm_cnt;

  logic accept;
  logic frame_end;
  logic run_end;
  logic clr_carry;
  logic sum;
  logic carry;
  logic cout;

  // start always wins over a bit offered in the same cycle.
  assign accept    = (state == ST_ACC) && bus.bit_valid && !bus.start;
  assign frame_end = accept && (bit_cnt == BW'(W - 1));
  assign run_end   = frame_end && (frm_cnt == FW'(K - 1));
  assign clr_carry = bus.start || frame_end;
  assign cout      = (acc[0] & bus.bit_in) | (acc[0] & carry) | (bus.bit_in & carry);
  assign bus.busy  = (state == ST_ACC);

  serial_fa_cell u_fa (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_carry),
    .en   (accept),
    .a    (acc[0]),
    .b    (bus.bit_in),
    .s    (sum),
    .co_q (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      acc              <= '0;
      bit_cnt          <= '0;
      frm_cnt          <= '0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.overflow     <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      if (bus.start) begin
        state        <= ST_ACC;
        acc          <= '0;
        bit_cnt      <= '0;
        frm_cnt      <= '0;
        bus.overflow <= 1'b0;
      end else begin
        case (state)
          ST_ACC: begin
            if (accept) begin
              // Rotating register: after W shifts the new sum sits LSB-aligned.
              acc     <= {sum, acc[W-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (frame_end) begin
                bit_cnt <= '0;
                frm_cnt <= frm_cnt + 1'b1;
                if (cout)
                  bus.overflow <= 1'b1;
              end
              if (run_end) begin
                state            <= ST_DONE;
                bus.result       <= {sum, acc[W-1:1]};
                bus.result_valid <= 1'b1;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_serial_mac_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_mac_accum: directed vector bench for serial_mac_accum.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serial_mac_accum;

  typedef struct {
    logic [7:0] f0;
    logic [7:0] f1;
    logic [7:0] exp_res;
    logic       exp_ovf;
    int         max_gap;
  } vec_t;

  vec_t vecs [5];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int passed  = 0;
  int total   = 0;
  int rv_a    = 0;
  int rv_b    = 0;
  int gap_err = 0;

  serial_mac_accum_if #(.W(8)) ba ();
  serial_mac_accum_if #(.W(4)) bb ();

  serial_mac_accum #(.W(8), .K(2)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
  serial_mac_accum #(.W(4), .K(1)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));

  always @(negedge clk) begin
    if (ba.result_valid) rv_a++;
    if (bb.result_valid) rv_b++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic start_a();
    @(negedge clk);
    ba.start = 1'b1; ba.bit_valid = 1'b0;
  endtask

  task automatic idle_a();
    @(negedge clk);
    ba.start = 1'b0; ba.bit_valid = 1'b0;
  endtask

  task automatic bit_a(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      ba.start = 1'b0; ba.bit_valid = 1'b0; ba.bit_in = 1'($urandom_range(0, 1));
      if (!ba.busy) gap_err++;
    end
    @(negedge clk);
    ba.start = 1'b0; ba.bit_valid = 1'b1; ba.bit_in = b;
  endtask

  task automatic frame_a(input logic [7:0] v, input int max_gap);
    for (int i = 0; i < 8; i++) bit_a(v[i], $urandom_range(0, max_gap));
  endtask

  initial begin
    logic [7:0] prev_res;
    logic [3:0] fb;
    int rv0;

    ba.start = 1'b0; ba.bit_valid = 1'b0; ba.bit_in = 1'b0;
    bb.start = 1'b0; bb.bit_valid = 1'b0; bb.bit_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy",     32'(ba.busy),         32'd0);
    check("reset_result",   32'(ba.result),       32'd0);
    check("reset_rvalid",   32'(ba.result_valid), 32'd0);
    check("reset_overflow", 32'(ba.overflow),     32'd0);
    rst = 1'b0;

    vecs[0] = '{8'h05, 8'h03, 8'h08, 1'b0, 0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 0};
    vecs[2] = '{8'h05, 8'h03, 8'h08, 1'b0, 5};
    vecs[3] = '{8'h80, 8'h7F, 8'hFF, 1'b0, 2};
    vecs[4] = '{8'hC8, 8'h64, 8'h2C, 1'b1, 0};
    prev_res = 8'h00;

    for (int v = 0; v < 5; v++) begin
      start_a();
      idle_a();
      rv0 = rv_a;
      check($sformatf("v%0d_ovf_cleared", v), 32'(ba.overflow), 32'd0);
      check($sformatf("v%0d_busy_run", v),    32'(ba.busy),     32'd1);
      check($sformatf("v%0d_result_held", v), 32'(ba.result),   32'(prev_res));
      gap_err = 0;
      frame_a(vecs[v].f0, vecs[v].max_gap);
      frame_a(vecs[v].f1, vecs[v].max_gap);
      idle_a();
      check($sformatf("v%0d_rvalid", v),   32'(ba.result_valid), 32'd1);
      check($sformatf("v%0d_busy_done", v), 32'(ba.busy),        32'd0);
      check($sformatf("v%0d_result", v),    32'(ba.result),      32'(vecs[v].exp_res));
      check($sformatf("v%0d_overflow", v),  32'(ba.overflow),    32'(vecs[v].exp_ovf));
      idle_a();
      check($sformatf("v%0d_rvalid_drop", v), 32'(ba.result_valid), 32'd0);
      check($sformatf("v%0d_ovf_sticky", v),  32'(ba.overflow),     32'(vecs[v].exp_ovf));
      check($sformatf("v%0d_pulses", v),      32'(rv_a - rv0),      32'd1);
      if (vecs[v].max_gap > 0)
        check($sformatf("v%0d_busy_gaps", v), 32'(gap_err), 32'd0);
      prev_res = vecs[v].exp_res;
    end

    // Reset in the middle of a run.
    start_a();
    for (int i = 0; i < 5; i++) bit_a(1'b1, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy",     32'(ba.busy),         32'd0);
    check("midrst_result",   32'(ba.result),       32'd0);
    check("midrst_rvalid",   32'(ba.result_valid), 32'd0);
    check("midrst_overflow", 32'(ba.overflow),     32'd0);
    @(negedge clk);
    rst = 1'b0; ba.bit_valid = 1'b0; ba.start = 1'b0;
    rv0 = rv_a;
    start_a();
    frame_a(8'hFF, 0);
    frame_a(8'hFF, 0);
    idle_a();
    check("postrst_result",   32'(ba.result),       32'h0FE);
    check("postrst_overflow", 32'(ba.overflow),     32'd1);
    check("postrst_rvalid",   32'(ba.result_valid), 32'd1);
    idle_a();
    check("postrst_pulses", 32'(rv_a - rv0), 32'd1);

    // Restart during frame 1 bit 3; the bit offered with start must be dropped.
    rv0 = rv_a;
    start_a();
    frame_a(8'h05, 0);
    bit_a(1'b1, 0);
    bit_a(1'b1, 0);
    bit_a(1'b0, 0);
    @(negedge clk);
    ba.start = 1'b1; ba.bit_valid = 1'b1; ba.bit_in = 1'b1;
    idle_a();
    check("restart_result_held", 32'(ba.result),       32'h0FE);
    check("restart_busy",        32'(ba.busy),         32'd1);
    check("restart_ovf_clr",     32'(ba.overflow),     32'd0);
    check("restart_no_rvalid",   32'(ba.result_valid), 32'd0);
    frame_a(8'h01, 0);
    frame_a(8'h01, 0);
    idle_a();
    check("restart_result",   32'(ba.result),       32'h002);
    check("restart_rvalid",   32'(ba.result_valid), 32'd1);
    check("restart_overflow", 32'(ba.overflow),     32'd0);
    idle_a();
    check("restart_pulses", 32'(rv_a - rv0), 32'd1);

    // W=4, K=1: bits offered while idle are ignored.
    rv0 = rv_b;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bb.start = 1'b0; bb.bit_valid = 1'b1; bb.bit_in = 1'(i & 1);
    end
    @(negedge clk);
    bb.bit_valid = 1'b0;
    check("k1_idle_busy",   32'(bb.busy),     32'd0);
    check("k1_idle_pulses", 32'(rv_b - rv0),  32'd0);
    @(negedge clk);
    bb.start = 1'b1;
    fb = 4'hA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bb.start = 1'b0; bb.bit_valid = 1'b1; bb.bit_in = fb[i];
      if (i == 3) check("k1_no_early_rvalid", 32'(bb.result_valid), 32'd0);
    end
    @(negedge clk);
    bb.bit_valid = 1'b0;
    check("k1_result",   32'(bb.result),       32'hA);
    check("k1_rvalid",   32'(bb.result_valid), 32'd1);
    check("k1_busy",     32'(bb.busy),         32'd0);
    check("k1_overflow", 32'(bb.overflow),     32'd0);
    @(negedge clk);
    check("k1_pulses",      32'(rv_b - rv0),  32'd1);
    check("k1_result_hold", 32'(bb.result),   32'hA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
